h2c_wdata_loader: RTL and testbench
===================================

Name: h2c_wdata_loader

Overview:
Host-to-card counterpart of the DRAM readback path. Accepts 256-bit AXI-Stream beats from the XDMA H2C channel and packs beat pairs into 512-bit DRAM write-data words. Buffers the words in an internal FIFO and presents them first-word-fall-through to the DRAM write datapath. Reports free space in 512-bit words so the host-side credit logic can throttle transfers.

Parameters:
AXI_W, 256, H2C stream data width; fixed at half of DRAM_W.
DRAM_W, 512, DRAM write word width (DQ_WIDTH*DQ_BURST).
DEPTH, 64, FIFO depth in DRAM_W words; power of two, ≥2.
CNT_W, $clog2(DEPTH)+1, width of occupancy and space counters.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
h2c_tdata_0  in  AXI_W  stream data
h2c_tvalid_0  in  1  stream valid
h2c_tready_0  out  1  stream ready
h2c_tlast_0  in  1  last beat of host transfer
h2c_tkeep_0  in  AXI_W/8  byte enables; all-ones required
flush  in  1  discard all buffered and half-packed data
wr_req  in  1  write datapath pops the head word
wr_data  out  DRAM_W  head word
wr_valid  out  1  head word valid
free_space  out  CNT_W  DEPTH minus occupancy, in words
pad_evt  out  1  one-cycle pulse: odd-length transfer padded
err_keep  out  1  sticky: beat accepted with tkeep not all-ones
err_underflow  out  1  sticky: wr_req while wr_valid low
checksum  out  32  running beat checksum (optional feature)

Behaviour:
- Reset values: h2c_tready_0=0 during the rst cycle; wr_valid=0; free_space=DEPTH; pad_evt=0; err_keep=0; err_underflow=0; checksum=0. Pointers, occupancy and packer state are cleared.
- Handshake: a beat is accepted when h2c_tvalid_0 && h2c_tready_0.
- h2c_tready_0 = ~rst && ~flush && (count < DEPTH).
  - Driven from registered count only.
  - No combinational path from wr_req.
- Packer FSM, two states:
  - LO: accepted beat → stored in half register as bits [255:0].
    - If tlast is also set: the word {256'b0, beat} is pushed, pad_evt pulses next cycle, and the FSM stays in LO.
    - Otherwise the FSM moves to HI.
  - HI: accepted beat → the word {beat, half_reg} is pushed and the FSM returns to LO. tlast in HI needs no padding.
- Push writes mem[wr_ptr] and increments wr_ptr (mod DEPTH).
  - Latency: the beat completing a word is accepted in cycle N; wr_valid/wr_data reflect that word in cycle N+1 if the FIFO was empty.
- Pop: wr_valid = (count != 0). wr_data = mem[rd_ptr], valid combinationally while wr_valid is high.
  - wr_req && wr_valid advances rd_ptr.
  - wr_req && ~wr_valid sets err_underflow; pointers are unchanged.
- Count/space:
  - Push and pop in the same cycle → count unchanged.
  - free_space = DEPTH - count, registered alongside count.
  - A lone LO-state beat held in the half register does not consume space.
- Full: count==DEPTH drops tready, including while the FSM is in HI. A pop in that cycle does not re-enable tready until the next cycle.
- Empty: wr_valid low; no output change on wr_req.
- err_keep: set on any accepted beat with tkeep != all-ones. The data is still packed. Cleared only by rst.
- flush, highest priority:
  - Same cycle: pointers, count and FSM→LO are cleared; push/pop are ignored; err flags are kept.
  - Next cycle: free_space=DEPTH.
- Pointer wrap is natural modulo DEPTH. count never exceeds DEPTH or goes below 0.

Optional Feature:
H2C_CHECKSUM_EN:
- Defined: on each accepted beat, checksum ← checksum XOR (XOR of the eight 32-bit lanes of h2c_tdata_0). checksum is cleared by rst and flush, and not cleared by tlast.
- Undefined: checksum is tied to 32'h0 and no XOR logic is instantiated. The port remains present.

Test Plan:
- Reset, then send two beats A=256'h1…1, B=256'h2…2 with tlast on B → one cycle later wr_valid=1, wr_data={B,A}, free_space=63. Pop → wr_valid=0, free_space=64.
- Send three beats with tlast on the third (C) → two words: {B,A}, then {256'b0,C}. pad_evt pulses exactly once. free_space=62.
- Stream 128 beats with wr_req=0 → tready falls after the 128th beat, count=64, free_space=0. One pop → tready returns the following cycle. Data order is preserved across the pointer wrap.
- Simultaneous push-completing beat and pop at count=5 → count stays 5 and free_space stays 59.
- Accept one LO beat, then assert flush → FSM back in LO, wr_valid=0, free_space=64. The next two beats form a fresh word with no stale half.
- Assert wr_req while empty → err_underflow=1 (sticky). Send a beat with tkeep=32'hFFFF_FFFE → err_keep=1. With H2C_CHECKSUM_EN, beat of lanes 1..8 → checksum=32'h8 (1^2^…^8); after flush, checksum=0.

Source files
------------

// File: rtl/h2c_wdata_loader.sv
// Packs pairs of 256-bit H2C stream beats into 512-bit DRAM write words and buffers them in a FWFT FIFO.
// Optional running beat checksum is enabled by defining H2C_CHECKSUM_EN.
module h2c_wdata_loader #(
  parameter int AXI_W  = 256,
  parameter int DRAM_W = 512,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AXI_W-1:0]     h2c_tdata_0,
  input  logic                 h2c_tvalid_0,
  output logic                 h2c_tready_0,
  input  logic                 h2c_tlast_0,
  input  logic [AXI_W/8-1:0]   h2c_tkeep_0,
  input  logic                 flush,
  input  logic                 wr_req,
  output logic [DRAM_W-1:0]    wr_data,
  output logic                 wr_valid,
  output logic [CNT_W-1:0]     free_space,
  output logic                 pad_evt,
  output logic                 err_keep,
  output logic                 err_underflow,
  output logic [31:0]          checksum
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic ST_LO = 1'b0;
  localparam logic ST_HI = 1'b1;

  logic [DRAM_W-1:0] mem [DEPTH];

  logic              state_q, state_d;
  logic [AXI_W-1:0]  half_q, half_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  free_space_q, free_space_d;
  logic              pad_evt_q, pad_evt_d;
  logic              err_keep_q, err_keep_d;
  logic              err_underflow_q, err_underflow_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic [DRAM_W-1:0] push_word;

  // Ready depends only on registered occupancy, so a pop cannot open the stream in the same cycle.
  assign h2c_tready_0 = ~rst & ~flush & (count_q < CNT_W'(DEPTH));
  assign accept       = h2c_tvalid_0 & h2c_tready_0;
  assign push         = accept & ((state_q == ST_HI) | h2c_tlast_0);
  assign pop          = wr_req & wr_valid & ~flush;
  assign push_word    = (state_q == ST_HI) ? {h2c_tdata_0, half_q}
                                           : {{(DRAM_W-AXI_W){1'b0}}, h2c_tdata_0};

  always_comb begin
    state_d         = state_q;
    half_d          = half_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    pad_evt_d       = 1'b0;
    err_keep_d      = err_keep_q;
    err_underflow_d = err_underflow_q;

    if (accept && (h2c_tkeep_0 != {(AXI_W/8){1'b1}})) begin
      err_keep_d = 1'b1;
    end
    if (wr_req && !wr_valid) begin
      err_underflow_d = 1'b1;
    end

    if (flush) begin
      state_d  = ST_LO;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        if (state_q == ST_LO) begin
          half_d = h2c_tdata_0;
          if (h2c_tlast_0) begin
            pad_evt_d = 1'b1;
          end else begin
            state_d = ST_HI;
          end
        end else begin
          state_d = ST_LO;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    free_space_d = CNT_W'(DEPTH) - count_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_LO;
      half_q          <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      free_space_q    <= CNT_W'(DEPTH);
      pad_evt_q       <= 1'b0;
      err_keep_q      <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      half_q          <= half_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      free_space_q    <= free_space_d;
      pad_evt_q       <= pad_evt_d;
      err_keep_q      <= err_keep_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  // Storage array carries no reset; contents are only observed while wr_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_word;
    end
  end

  assign wr_valid      = (count_q != '0);
  assign wr_data       = mem[rd_ptr_q];
  assign free_space    = free_space_q;
  assign pad_evt       = pad_evt_q;
  assign err_keep      = err_keep_q;
  assign err_underflow = err_underflow_q;

`ifdef H2C_CHECKSUM_EN
  localparam int LANES = AXI_W / 32;

  logic [31:0] lane_w [LANES];
  logic [31:0] lane_xor;
  logic [31:0] checksum_q, checksum_d;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_w[gi] = h2c_tdata_0[gi*32 +: 32];
  end

  always_comb begin
    lane_xor = 32'h0;
    for (int i = 0; i < LANES; i++) begin
      lane_xor = lane_xor ^ lane_w[i];
    end
    checksum_d = checksum_q;
    if (flush) begin
      checksum_d = 32'h0;
    end else if (accept) begin
      checksum_d = checksum_q ^ lane_xor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= 32'h0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_h2c_wdata_loader.sv
// Directed bench for h2c_wdata_loader: packing, padding, full/wrap, flush, error flags and checksum.
module tb_h2c_wdata_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] h2c_tdata_0;
  logic         h2c_tvalid_0;
  logic         h2c_tready_0;
  logic         h2c_tlast_0;
  logic [31:0]  h2c_tkeep_0;
  logic         flush;
  logic         wr_req;
  logic [511:0] wr_data;
  logic         wr_valid;
  logic [6:0]   free_space;
  logic         pad_evt;
  logic         err_keep;
  logic         err_underflow;
  logic [31:0]  checksum;

  int checks = 0;
  int errors = 0;

`ifdef H2C_CHECKSUM_EN
  localparam logic [31:0] CSUM_EXP = 32'h8;
`else
  localparam logic [31:0] CSUM_EXP = 32'h0;
`endif

  h2c_wdata_loader dut (
    .clk           (clk),
    .rst           (rst),
    .h2c_tdata_0   (h2c_tdata_0),
    .h2c_tvalid_0  (h2c_tvalid_0),
    .h2c_tready_0  (h2c_tready_0),
    .h2c_tlast_0   (h2c_tlast_0),
    .h2c_tkeep_0   (h2c_tkeep_0),
    .flush         (flush),
    .wr_req        (wr_req),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .free_space    (free_space),
    .pad_evt       (pad_evt),
    .err_keep      (err_keep),
    .err_underflow (err_underflow),
    .checksum      (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] beat(input int i);
    logic [31:0] w;
    w = i;
    return {8{w}};
  endfunction

  task automatic send(input logic [255:0] d, input logic l, input logic [31:0] k);
    h2c_tvalid_0 = 1'b1;
    h2c_tdata_0  = d;
    h2c_tlast_0  = l;
    h2c_tkeep_0  = k;
    tick();
    h2c_tvalid_0 = 1'b0;
    h2c_tlast_0  = 1'b0;
    h2c_tkeep_0  = '1;
    $display("beat lane0=%h last=%0b keep=%h free=%0d", d[31:0], l, k, free_space);
  endtask

  task automatic pop();
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    $display("pop free=%0d valid=%0b", free_space, wr_valid);
  endtask

  initial begin
    logic [255:0] a_beat, b_beat, c_beat, lanes;
    a_beat = {64{4'h1}};
    b_beat = {64{4'h2}};
    c_beat = {64{4'h3}};
    lanes  = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};

    rst = 1'b1; h2c_tvalid_0 = 1'b0; h2c_tdata_0 = '0; h2c_tlast_0 = 1'b0;
    h2c_tkeep_0 = '1; flush = 1'b0; wr_req = 1'b0;
    tick();
    tick();
    check("rst_tready", h2c_tready_0, 0);
    check("rst_valid", wr_valid, 0);
    check("rst_free", free_space, 64);
    check("rst_pad", pad_evt, 0);
    check("rst_errk", err_keep, 0);
    check("rst_erru", err_underflow, 0);
    check("rst_csum", checksum, 0);
    rst = 1'b0;
    #1;
    check("tready_after_rst", h2c_tready_0, 1);

    // Two-beat word
    send(a_beat, 1'b0, '1);
    check("half_no_space", free_space, 64);
    check("half_no_valid", wr_valid, 0);
    send(b_beat, 1'b1, '1);
    check("pair_valid", wr_valid, 1);
    check("pair_data", wr_data, {b_beat, a_beat});
    check("pair_free", free_space, 63);
    check("pair_nopad", pad_evt, 0);
    pop();
    check("pair_pop_valid", wr_valid, 0);
    check("pair_pop_free", free_space, 64);

    // Three beats, odd length padded
    send(a_beat, 1'b0, '1);
    check("odd_pad0", pad_evt, 0);
    send(b_beat, 1'b0, '1);
    check("odd_pad1", pad_evt, 0);
    send(c_beat, 1'b1, '1);
    check("odd_pad2", pad_evt, 1);
    check("odd_free", free_space, 62);
    tick();
    check("odd_pad3", pad_evt, 0);
    check("odd_w0", wr_data, {b_beat, a_beat});
    pop();
    check("odd_w1", wr_data, {256'b0, c_beat});
    pop();
    check("odd_empty_free", free_space, 64);

    // Fill to full across the pointer wrap
    for (int i = 0; i < 128; i++) begin
      check("fill_tready", h2c_tready_0, 1);
      send(beat(i), 1'b0, '1);
    end
    check("full_tready", h2c_tready_0, 0);
    check("full_free", free_space, 0);
    check("full_valid", wr_valid, 1);
    check("full_w0", wr_data, {beat(1), beat(0)});
    wr_req = 1'b1;
    #1;
    check("full_pop_same_cycle", h2c_tready_0, 0);
    tick();
    wr_req = 1'b0;
    check("full_pop_next_tready", h2c_tready_0, 1);
    check("full_pop_free", free_space, 1);
    for (int j = 1; j < 64; j++) begin
      check("wrap_order", wr_data, {beat(2*j+1), beat(2*j)});
      pop();
    end
    check("drain_free", free_space, 64);
    check("drain_valid", wr_valid, 0);

    // Push-completing beat with a concurrent pop at count 5
    for (int i = 200; i < 210; i++) send(beat(i), 1'b0, '1);
    check("cnt5_free", free_space, 59);
    send(beat(300), 1'b0, '1);
    h2c_tvalid_0 = 1'b1; h2c_tdata_0 = beat(301); wr_req = 1'b1;
    tick();
    h2c_tvalid_0 = 1'b0; wr_req = 1'b0;
    check("pushpop_free", free_space, 59);
    check("pushpop_head", wr_data, {beat(203), beat(202)});

    // Flush with a half-packed beat pending
    send(beat(400), 1'b0, '1);
    flush = 1'b1;
    #1;
    check("flush_tready", h2c_tready_0, 0);
    tick();
    flush = 1'b0;
    check("flush_valid", wr_valid, 0);
    check("flush_free", free_space, 64);
    send(beat(500), 1'b0, '1);
    check("flush_lo_state", wr_valid, 0);
    send(beat(501), 1'b0, '1);
    check("flush_fresh_word", wr_data, {beat(501), beat(500)});
    check("flush_fresh_free", free_space, 63);
    pop();

    // Error flags
    check("erru_before", err_underflow, 0);
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    check("erru_set", err_underflow, 1);
    check("erru_free", free_space, 64);
    tick();
    check("erru_sticky", err_underflow, 1);
    send(beat(600), 1'b1, 32'hFFFF_FFFE);
    check("errk_set", err_keep, 1);
    check("errk_pad", pad_evt, 1);
    check("errk_data", wr_data, {256'b0, beat(600)});
    pop();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_keeps_errk", err_keep, 1);
    check("flush_keeps_erru", err_underflow, 1);

    // Checksum
    check("csum_cleared", checksum, 0);
    send(lanes, 1'b1, '1);
    check("csum_lanes", checksum, CSUM_EXP);
    pop();
    check("csum_kept_on_pop", checksum, CSUM_EXP);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("csum_flush", checksum, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
